// File: rtl/sn76489_pkg.sv
// Shared SN76489 encodings: channel/register codes, byte field positions,
// request bundle and helpers that build latch and data bytes.
package sn76489_pkg;

  typedef enum logic [1:0] {
    CH_TONE1 = 2'd0,
    CH_TONE2 = 2'd1,
    CH_TONE3 = 2'd2,
    CH_NOISE = 2'd3
  } psg_ch_e;

  typedef enum logic {
    REG_FREQ = 1'b0,
    REG_ATT  = 1'b1
  } psg_reg_e;

  localparam int LATCH_FLAG_BIT = 7;
  localparam int CH_MSB         = 6;
  localparam int CH_LSB         = 5;
  localparam int TYPE_BIT       = 4;
  localparam int LOW_MSB        = 3;
  localparam int DATA_MSB       = 5;

  typedef struct packed {
    logic [1:0] ch;
    logic       typ;
    logic [9:0] value;
  } psg_req_t;

  function automatic logic psg_has_data(
    input logic [1:0] ch,
    input logic       typ
  );
    return (typ == REG_FREQ) && (ch != CH_NOISE);
  endfunction

  function automatic logic [7:0] psg_latch_byte(
    input logic [1:0] ch,
    input logic       typ,
    input logic [3:0] v_lo
  );
    logic [7:0] b;
    logic [3:0] low;
    // noise control only carries 3 bits
    if ((ch == CH_NOISE) && (typ == REG_FREQ))
      low = {1'b0, v_lo[2:0]};
    else
      low = v_lo;
    b = '0;
    b[LATCH_FLAG_BIT]  = 1'b1;
    b[CH_MSB:CH_LSB]   = ch;
    b[TYPE_BIT]        = typ;
    b[LOW_MSB:0]       = low;
    return b;
  endfunction

  function automatic logic [7:0] psg_data_byte(
    input logic [5:0] v_hi
  );
    logic [7:0] b;
    b = '0;
    b[DATA_MSB:0] = v_hi;
    return b;
  endfunction

endpackage

// File: rtl/sn76489_writer_fifo.sv
// Request FIFO for the PSG bus writer.
// push_i/pop_i are ignored when full/empty; rdata_o shows the head entry.
module sn76489_writer_fifo
  import sn76489_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  psg_req_t                   wdata_i,
  input  logic                       pop_i,
  output psg_req_t                   rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  psg_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/sn76489_bus_writer.sv
// Serialises queued PSG register writes into latch/data bytes on d/nCE/nWE,
// holding each strobe until ready (or timeout). Sticky error on timeout.
module sn76489_bus_writer
  import sn76489_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_MIN    = 2,
  parameter int READY_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_channel,
  input  logic       req_type,
  input  logic [9:0] req_value,
  output logic [7:0] d,
  output logic       nWE,
  output logic       nCE,
  input  logic       ready,
  output logic       busy,
  output logic       error
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST =
    CNT_W'(STROBE_MIN > 0 ? STROBE_MIN - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(READY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, RELEASE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       data_q, data_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  psg_req_t                    wreq, head;
  logic                        fifo_pop;
  logic                        fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign wreq = {req_channel, req_type, req_value};

  sn76489_writer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (req_valid),
    .wdata_i (wreq),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    data_d   = data_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          byte_d   = psg_latch_byte(head.ch, head.typ,
                                    head.value[3:0]);
          data_d   = psg_data_byte(head.value[9:4]);
          pend_d   = psg_has_data(head.ch, head.typ);
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q >= SETUP_LAST) begin
          cnt_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if ((cnt_q >= STROBE_LAST) && ready) begin
          state_d = RELEASE;
        end else if (cnt_q >= TMO_LAST) begin
          // abandon the whole request, data byte included
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = RELEASE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (pend_q) begin
          byte_d  = data_q;
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      byte_q  <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign d         = byte_q;
  assign nCE       = !((state_q == SETUP) || (state_q == STROBE));
  assign nWE       = (state_q != STROBE);
  assign busy      = (fifo_cnt != '0) || (state_q != IDLE);
  assign req_ready = !fifo_full;
  assign error     = err_q;

endmodule
